// File: rtl/mem_access.sv
// MEM stage: performs LB/LW/SB/SW over a req/ack bus with byte-lane steering,
// LB sign extension and an ack timeout; registers write-back results for WB.
module mem_access #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_sdata_i,
    input  logic        wreg_en_i,
    input  logic [4:0]  wreg_addr_i,
    input  logic [31:0] wreg_data_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stall_req_o,
    output logic        wb_en_o,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            abort_q;
    logic            load_q;
    logic            byte_q;
    logic [1:0]      lane_q;
    logic [31:0]     rdata_q;

    logic        is_lb, is_lw, is_sb, is_sw, is_mem, is_word, misaligned, start;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  rbyte;

    always_comb begin
        is_lb      = (mem_op_i == 3'd1);
        is_lw      = (mem_op_i == 3'd2);
        is_sb      = (mem_op_i == 3'd3);
        is_sw      = (mem_op_i == 3'd4);
        is_mem     = is_lb | is_lw | is_sb | is_sw;
        is_word    = is_lw | is_sw;
        misaligned = is_word && (mem_addr_i[1:0] != 2'b00);
        start      = is_mem && !misaligned;
        be_d       = is_word ? 4'hF : (4'b0001 << mem_addr_i[1:0]);
        wdata_d    = is_sb ? {4{mem_sdata_i[7:0]}} : mem_sdata_i;
        rbyte      = bus_rdata_i[{lane_q, 3'b000} +: 8];
    end

    // DONE never stalls so the next instruction is accepted on the DONE edge.
    always_comb begin
        stall_req_o = ((state_q == StIdle) && start) || (state_q == StReq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            abort_q     <= 1'b0;
            load_q      <= 1'b0;
            byte_q      <= 1'b0;
            lane_q      <= 2'b00;
            rdata_q     <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= '0;
            bus_wdata_o <= '0;
            wb_en_o     <= 1'b0;
            wb_addr_o   <= '0;
            wb_data_o   <= '0;
            misalign_o  <= 1'b0;
            bus_err_o   <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StReq;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= is_sb | is_sw;
                        bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        bus_be_o    <= be_d;
                        bus_wdata_o <= wdata_d;
                        cnt_q       <= '0;
                        abort_q     <= 1'b0;
                        load_q      <= is_lb | is_lw;
                        byte_q      <= is_lb;
                        lane_q      <= mem_addr_i[1:0];
                        wb_en_o     <= 1'b0;
                    end else if (misaligned) begin
                        wb_en_o    <= 1'b0;
                        misalign_o <= 1'b1;
                    end else begin
                        wb_en_o   <= wreg_en_i;
                        wb_addr_o <= wreg_addr_i;
                        wb_data_o <= wreg_data_i;
                    end
                end
                StReq: begin
                    wb_en_o <= 1'b0;
                    // Ack is tested first so it wins over a simultaneous expiry.
                    if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                        rdata_q   <= byte_q ? {{24{rbyte[7]}}, rbyte} : bus_rdata_i;
                        state_q   <= StDone;
                    end else if (ACK_TIMEOUT != 0) begin
                        if (cnt_q == CntLast) begin
                            bus_req_o <= 1'b0;
                            bus_err_o <= 1'b1;
                            abort_q   <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                StDone: begin
                    if (load_q && !abort_q) begin
                        wb_en_o   <= wreg_en_i;
                        wb_addr_o <= wreg_addr_i;
                        wb_data_o <= rdata_q;
                    end else begin
                        wb_en_o <= 1'b0;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: transaction-level expectation model checked every cycle,
// plus directed cases with literal expectations and a randomized op stream.
module tb_mem_access;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst;
    logic [2:0]  mem_op_i;
    logic [31:0] mem_addr_i, mem_sdata_i, wreg_data_i, bus_rdata_i;
    logic        wreg_en_i, bus_ack_i;
    logic [4:0]  wreg_addr_i;
    logic        bus_req_o, bus_we_o, stall_req_o, wb_en_o, misalign_o, bus_err_o;
    logic [31:0] bus_addr_o, bus_wdata_o, wb_data_o;
    logic [3:0]  bus_be_o;
    logic [4:0]  wb_addr_o;

    mem_access #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
        .wreg_en_i(wreg_en_i), .wreg_addr_i(wreg_addr_i), .wreg_data_i(wreg_data_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .stall_req_o(stall_req_o), .wb_en_o(wb_en_o), .wb_addr_o(wb_addr_o),
        .wb_data_o(wb_data_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    bit chk_en = 0;

    logic        exp_req, exp_we, exp_stall, exp_wben, exp_mis, exp_err, exp_store;
    logic [31:0] exp_addr, exp_wdata, exp_wbdata;
    logic [3:0]  exp_be;
    logic [4:0]  exp_wbaddr;

    int stall_cnt = 0, req_cnt = 0, err_cnt = 0;
    logic [31:0] last_addr = 0, last_wdata = 0;
    logic [3:0]  last_be = 0;
    logic        last_we = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("bus_req", bus_req_o, exp_req);
            chk("stall", stall_req_o, exp_stall);
            chk("wb_en", wb_en_o, exp_wben);
            chk("misalign", misalign_o, exp_mis);
            chk("bus_err", bus_err_o, exp_err);
            if (exp_req) begin
                chk("bus_we", bus_we_o, exp_we);
                chk("bus_addr", bus_addr_o, exp_addr);
                chk("bus_be", bus_be_o, exp_be);
                if (exp_store) chk("bus_wdata", bus_wdata_o, exp_wdata);
            end
            if (exp_wben) begin
                chk("wb_addr", wb_addr_o, exp_wbaddr);
                chk("wb_data", wb_data_o, exp_wbdata);
            end
            if (stall_req_o) stall_cnt++;
            if (bus_err_o) err_cnt++;
            if (bus_req_o) begin
                req_cnt++;
                last_addr = bus_addr_o;
                last_be = bus_be_o;
                last_wdata = bus_wdata_o;
                last_we = bus_we_o;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        exp_mis = 0;
        exp_err = 0;
    endtask

    task automatic clr();
        stall_cnt = 0;
        req_cnt = 0;
        err_cnt = 0;
    endtask

    // Presents one instruction, plays the bus slave, and advances the
    // expectations by what each edge must do according to the stage's rules.
    task automatic do_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int waits, input bit no_ack,
                         input int rst_at);
        bit mem, word, mis, store, load, aborted, expire, ack;
        logic [31:0] cap, rb;
        cap = 0;
        mem = (op >= 1) && (op <= 4);
        word = (op == 2) || (op == 4);
        store = (op == 3) || (op == 4);
        load = (op == 1) || (op == 2);
        mis = word && (addr[1:0] != 2'b00);
        mem_op_i = op; mem_addr_i = addr; mem_sdata_i = sdata;
        wreg_en_i = wen; wreg_addr_i = waddr; wreg_data_i = wdata;
        bus_ack_i = 1'($urandom_range(0, 1));
        bus_rdata_i = $urandom();
        exp_stall = mem && !mis;
        tick();
        if (!mem) begin
            exp_wben = wen; exp_wbaddr = waddr; exp_wbdata = wdata;
            return;
        end
        if (mis) begin
            exp_wben = 0; exp_mis = 1;
            return;
        end
        exp_req = 1; exp_we = store; exp_store = store;
        exp_addr = {addr[31:2], 2'b00};
        exp_be = word ? 4'hF : (4'b0001 << addr[1:0]);
        exp_wdata = (op == 3) ? {4{sdata[7:0]}} : sdata;
        exp_wben = 0;
        aborted = 0;
        for (int i = 0; i < 1000; i++) begin
            ack = !no_ack && (i == waits);
            expire = !ack && (TO != 0) && (i == TO - 1);
            bus_ack_i = ack;
            bus_rdata_i = ack ? rdata : $urandom();
            if (i == rst_at) begin
                rst = 1; bus_ack_i = 0;
                tick();
                rst = 0; exp_req = 0; exp_wben = 0;
                mem_op_i = 0; wreg_en_i = 0; exp_stall = 0;
                return;
            end
            tick();
            if (ack) begin
                exp_req = 0;
                rb = rdata >> (8 * addr[1:0]);
                cap = (op == 1) ? {{24{rb[7]}}, rb[7:0]} : rdata;
                break;
            end
            if (expire) begin
                exp_req = 0; exp_err = 1; aborted = 1;
                break;
            end
        end
        bus_ack_i = 1'($urandom_range(0, 1));
        bus_rdata_i = $urandom();
        exp_stall = 0;
        tick();
        if (load && !aborted) begin
            exp_wben = wen; exp_wbaddr = waddr; exp_wbdata = cap;
        end else begin
            exp_wben = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] op;
        logic [31:0] addr;
        rst = 1; mem_op_i = 0; mem_addr_i = 0; mem_sdata_i = 0;
        wreg_en_i = 0; wreg_addr_i = 0; wreg_data_i = 0; bus_ack_i = 0; bus_rdata_i = 0;
        exp_req = 0; exp_we = 0; exp_stall = 0; exp_wben = 0; exp_mis = 0; exp_err = 0;
        exp_store = 0; exp_addr = 0; exp_wdata = 0; exp_wbdata = 0; exp_be = 0; exp_wbaddr = 0;
        repeat (3) tick();
        chk("rst_req", bus_req_o, 0);
        chk("rst_stall", stall_req_o, 0);
        chk("rst_wben", wb_en_o, 0);
        chk("rst_wbaddr", wb_addr_o, 0);
        chk("rst_wbdata", wb_data_o, 0);
        chk("rst_mis", misalign_o, 0);
        chk("rst_err", bus_err_o, 0);
        rst = 0;
        chk_en = 1;

        clr(); do_op(3'd0, 0, 0, 1, 5'd3, 32'h1234, 0, 0, 0, -1);
        chk("none_wben", wb_en_o, 1);
        chk("none_wbaddr", wb_addr_o, 3);
        chk("none_wbdata", wb_data_o, 32'h1234);
        chk("none_stall_cnt", stall_cnt, 0);

        clr(); do_op(3'd1, 32'h1002, 0, 1, 5'd7, 0, 32'h0080_0000, 0, 0, -1);
        chk("lb_addr", last_addr, 32'h1000);
        chk("lb_be", last_be, 4'b0100);
        chk("lb_we", last_we, 0);
        chk("lb_stall_cnt", stall_cnt, 2);
        chk("lb_wben", wb_en_o, 1);
        chk("lb_wbdata", wb_data_o, 32'hFFFF_FF80);

        clr(); do_op(3'd4, 32'h2000, 32'hDEAD_BEEF, 1, 5'd9, 0, 0, 3, 0, -1);
        chk("sw_req_cnt", req_cnt, 4);
        chk("sw_be", last_be, 4'hF);
        chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);
        chk("sw_we", last_we, 1);
        chk("sw_stall_cnt", stall_cnt, 5);
        chk("sw_wben", wb_en_o, 0);

        clr(); do_op(3'd3, 32'h2003, 32'h0000_00AB, 0, 5'd1, 0, 0, 0, 0, -1);
        chk("sb_be", last_be, 4'b1000);
        chk("sb_wdata", last_wdata, 32'hABAB_ABAB);

        clr(); do_op(3'd2, 32'h3001, 0, 1, 5'd2, 0, 0, 0, 0, -1);
        chk("mis_pulse", misalign_o, 1);
        chk("mis_wben", wb_en_o, 0);
        chk("mis_req_cnt", req_cnt, 0);
        chk("mis_stall_cnt", stall_cnt, 0);

        clr(); do_op(3'd2, 32'h4000, 0, 1, 5'd4, 0, 0, 0, 1, -1);
        chk("to_req_cnt", req_cnt, 16);
        chk("to_err_cnt", err_cnt, 1);
        chk("to_wben", wb_en_o, 0);

        clr(); do_op(3'd2, 32'h5000, 0, 1, 5'd4, 0, 0, 0, 1, 5);
        chk("rst_mid_req", bus_req_o, 0);
        chk("rst_mid_req_cnt", req_cnt, 6);
        do_op(3'd0, 0, 0, 1, 5'd4, 32'h55, 0, 0, 0, -1);
        chk("rst_mid_idle", wb_data_o, 32'h55);
        chk("rst_mid_err_cnt", err_cnt, 0);

        for (int n = 0; n < 400; n++) begin
            op = 3'($urandom_range(0, 7));
            addr = $urandom();
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            do_op(op, addr, $urandom(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  $urandom(), $urandom(), int'($urandom_range(0, 5)),
                  $urandom_range(0, 15) == 0, -1);
        end
        tick();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
